alu_serial: RTL and testbench

- Parametrised bit-serial successor to the team's 1-bit ALU.
- Accepts WIDTH-bit operands and processes one bit per clock, LSB first, through a single 1-bit slice with a carry register.
- Adds arithmetic operations (increment, add, subtract) and Carry/Zero flags.
- Uses a Start/Busy/Done handshake, for use where area matters more than throughput.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_bit_slice.sv | 39 +++
 rtl/alu_serial.sv | 140 ++++++++++++++
 tb/tb_alu_serial.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the bit-serial ALU.
package alu_pkg;

    localparam logic MODE_LOGIC = 1'b0;
    localparam logic MODE_ARITH = 1'b1;

    localparam logic [1:0] SEL_PASS     = 2'b00;
    localparam logic [1:0] SEL_NOT_INC  = 2'b01;
    localparam logic [1:0] SEL_XOR_ADD  = 2'b10;
    localparam logic [1:0] SEL_XNOR_SUB = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: logic ops, or a full adder with optional B inversion for subtract.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] Select,
    input  logic       Mode,
    output logic       r,
    output logic       cout
);

    logic b_eff;

    always_comb begin
        r     = 1'b0;
        cout  = 1'b0;
        b_eff = 1'b0;
        if (Mode == MODE_LOGIC) begin
            case (Select)
                SEL_PASS:    r = a;
                SEL_NOT_INC: r = ~a;
                SEL_XOR_ADD: r = a ^ b;
                default:     r = ~(a ^ b);
            endcase
        end else begin
            // Transfer and increment ignore B; subtract adds ~B with carry-in 1.
            case (Select)
                SEL_XOR_ADD:  b_eff = b;
                SEL_XNOR_SUB: b_eff = ~b;
                default:      b_eff = 1'b0;
            endcase
            r    = a ^ b_eff ^ cin;
            cout = (a & b_eff) | (a & cin) | (b_eff & cin);
        end
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU: WIDTH-bit operands processed LSB first through one slice,
// with a Start/Busy/Done handshake and Carry/Zero flags.
module alu_serial
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Select,
    input  logic             Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Zero
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               carry_q;
    logic [1:0]         sel_q;
    logic               mode_q;

    logic               load_c;
    logic               step_c;
    logic               last_c;
    logic               bit_r;
    logic               bit_cout;
    logic [WIDTH:0]     res_shift;
    logic [WIDTH-1:0]   res_next;

    alu_bit_slice u_slice (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .cin    (carry_q),
        .Select (sel_q),
        .Mode   (mode_q),
        .r      (bit_r),
        .cout   (bit_cout)
    );

    // New result bit enters at the MSB; written this way so WIDTH=1 needs no special case.
    assign res_shift = {bit_r, res_sr};
    assign res_next  = res_shift[WIDTH:1];

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control strobes derived from the current state
    always_comb begin
        load_c = 1'b0;
        step_c = 1'b0;
        last_c = 1'b0;
        case (state_q)
            IDLE: load_c = Start;
            RUN: begin
                step_c = 1'b1;
                last_c = (cnt_q == CNT_W'(WIDTH - 1));
            end
            default: ;
        endcase
    end

    // Operand/result shifters, carry chain and bit counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= SEL_PASS;
            mode_q  <= MODE_LOGIC;
        end else if (load_c) begin
            a_sr    <= A;
            b_sr    <= B;
            res_sr  <= '0;
            sel_q   <= Select;
            mode_q  <= Mode;
            // Increment and subtract both start with carry-in 1.
            carry_q <= (Mode == MODE_ARITH) && Select[0];
            cnt_q   <= '0;
        end else if (step_c) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            res_sr  <= res_next;
            carry_q <= bit_cout;
            cnt_q   <= last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Handshake and architectural outputs; Result/flags only move on the final bit
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Result <= '0;
            Carry  <= 1'b0;
            Zero   <= 1'b0;
        end else begin
            Done <= last_c;
            if (load_c) begin
                Busy <= 1'b1;
            end else if (last_c) begin
                Busy <= 1'b0;
            end
            if (last_c) begin
                Result <= res_next;
                Carry  <= (mode_q == MODE_ARITH) ? bit_cout : 1'b0;
                Zero   <= (res_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Directed plus randomized checks of alu_serial (WIDTH=8 and WIDTH=1 instances)
// against an arithmetic reference model.
module tb_alu_serial;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start;
    logic [1:0] sel;
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry;
    logic       zero;

    logic       start1;
    logic [1:0] sel1;
    logic       mode1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] result1;
    logic       carry1;
    logic       zero1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(8)) dut (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .Select(sel), .Mode(mode),
        .A(a), .B(b), .Busy(busy), .Done(done), .Result(result),
        .Carry(carry), .Zero(zero)
    );

    alu_serial #(.WIDTH(1)) dut1 (
        .Clk(clk), .Reset_n(rst_n), .Start(start1), .Select(sel1), .Mode(mode1),
        .A(a1), .B(b1), .Busy(busy1), .Done(done1), .Result(result1),
        .Carry(carry1), .Zero(zero1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: {carry, result} from plain 8-bit arithmetic.
    function automatic logic [8:0] model(input logic [1:0] s, input logic m,
                                         input logic [7:0] x, input logic [7:0] y);
        int unsigned t;
        logic [8:0]  o;
        o = '0;
        if (!m) begin
            case (s)
                2'd0:    o = {1'b0, x};
                2'd1:    o = {1'b0, ~x};
                2'd2:    o = {1'b0, x ^ y};
                default: o = {1'b0, ~(x ^ y)};
            endcase
        end else begin
            case (s)
                2'd0: o = {1'b0, x};
                2'd1: begin
                    t = 32'(x) + 1;
                    o = 9'(t);
                end
                2'd2: begin
                    t = 32'(x) + 32'(y);
                    o = 9'(t);
                end
                default: o = {(x >= y), 8'(int'(x) - int'(y))};
            endcase
        end
        return o;
    endfunction

    function automatic logic legacy(input logic [1:0] s, input logic x, input logic y);
        case (s)
            2'd0:    return x;
            2'd1:    return ~x;
            2'd2:    return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    // Called at a negedge; returns just after the accepting edge.
    task automatic launch(input logic [1:0] s, input logic m, input logic [7:0] x, input logic [7:0] y);
        sel   = s;
        mode  = m;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for Done (bounded) and checks the handshake and results; ends at the Done negedge
    // unless check_pulse consumes one more cycle.
    task automatic finish_op(input string tag, input logic [1:0] s, input logic m,
                             input logic [7:0] x, input logic [7:0] y,
                             input bit repulse, input bit check_pulse);
        logic [8:0] exp;
        logic [7:0] held;
        int         cycles;
        bit         got;
        bit         moved;
        int         extra;
        exp    = model(s, m, x, y);
        held   = result;
        cycles = 0;
        got    = 1'b0;
        moved  = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) cycles++;
                if (result !== held) moved = 1'b1;
                if (repulse && (cycles == 3 || cycles == 5)) begin
                    start = 1'b1;
                    a     = 8'($urandom);
                    sel   = 2'($urandom);
                end
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'(1));
        check({tag, "_busy_cycles"}, 32'(cycles), 32'(8));
        check({tag, "_result_held"}, 32'(moved), 32'(0));
        check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
        check({tag, "_result"}, 32'(result), 32'(exp[7:0]));
        check({tag, "_carry"}, 32'(carry), 32'(exp[8]));
        check({tag, "_zero"}, 32'(zero), 32'(exp[7:0] == 8'h00));
        if (check_pulse) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(done), 32'(0));
        end
        if (repulse) begin
            extra = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check({tag, "_single_done"}, 32'(extra), 32'(0));
        end
    endtask

    initial begin
        logic [1:0] s;
        logic       m;
        logic [7:0] x;
        logic [7:0] y;
        int         dones;

        rst_n  = 1'b0;
        start  = 1'b0; sel  = 2'd0; mode  = 1'b0; a  = '0; b  = '0;
        start1 = 1'b0; sel1 = 2'd0; mode1 = 1'b0; a1 = '0; b1 = '0;
        #12;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_carry", 32'(carry), 32'(0));
        check("rst_zero", 32'(zero), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        launch(2'b10, 1'b0, 8'h5A, 8'h0F);
        finish_op("xor", 2'b10, 1'b0, 8'h5A, 8'h0F, 1'b0, 1'b1);
        check("xor_const", 32'(result), 32'(8'h55));

        @(negedge clk);
        launch(2'b10, 1'b1, 8'hFF, 8'h01);
        finish_op("add_wrap", 2'b10, 1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        check("add_wrap_const", 32'({carry, zero, result}), 32'({1'b1, 1'b1, 8'h00}));

        @(negedge clk);
        launch(2'b11, 1'b1, 8'h10, 8'h20);
        finish_op("sub_borrow", 2'b11, 1'b1, 8'h10, 8'h20, 1'b0, 1'b1);
        check("sub_borrow_const", 32'({carry, result}), 32'({1'b0, 8'hF0}));

        @(negedge clk);
        launch(2'b11, 1'b1, 8'h20, 8'h20);
        finish_op("sub_equal", 2'b11, 1'b1, 8'h20, 8'h20, 1'b0, 1'b1);

        @(negedge clk);
        launch(2'b01, 1'b1, 8'h7F, 8'h00);
        finish_op("inc_repulse", 2'b01, 1'b1, 8'h7F, 8'h00, 1'b1, 1'b0);
        check("inc_const", 32'(result), 32'(8'h80));

        // Back-to-back: next Start issued in the Done cycle.
        @(negedge clk);
        launch(2'b10, 1'b1, 8'h12, 8'h34);
        finish_op("b2b_first", 2'b10, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        launch(2'b01, 1'b0, 8'h00, 8'h00);
        finish_op("b2b_second", 2'b01, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("b2b_const", 32'(result), 32'(8'hFF));

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        launch(2'b10, 1'b1, 8'h01, 8'h02);
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        check("abort_carry", 32'(carry), 32'(0));
        check("abort_zero", 32'(zero), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("abort_no_done", 32'(dones), 32'(0));

        for (int i = 0; i < 24; i++) begin
            s = 2'($urandom);
            m = 1'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            if (i == 0) begin
                x = 8'h00;
                y = 8'h00;
            end
            @(negedge clk);
            launch(s, m, x, y);
            finish_op("rnd", s, m, x, y, 1'b0, 1'b1);
        end

        // WIDTH=1 logic sweep against the legacy truth table.
        for (int si = 0; si < 4; si++) begin
            for (int xi = 0; xi < 2; xi++) begin
                for (int yi = 0; yi < 2; yi++) begin
                    @(negedge clk);
                    sel1   = 2'(si);
                    mode1  = 1'b0;
                    a1     = 1'(xi);
                    b1     = 1'(yi);
                    start1 = 1'b1;
                    @(posedge clk);
                    #1 start1 = 1'b0;
                    @(negedge clk);
                    check("w1_busy", 32'(busy1), 32'(1));
                    @(negedge clk);
                    check("w1_done", 32'(done1), 32'(1));
                    check("w1_result", 32'(result1),
                          32'(legacy(2'(si), 1'(xi), 1'(yi))));
                    check("w1_carry", 32'(carry1), 32'(0));
                    check("w1_zero", 32'(zero1),
                          32'(!legacy(2'(si), 1'(xi), 1'(yi))));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
